// File: rtl/cam_entry_mgr_pkg.sv
// rtl/cam_entry_mgr_pkg.sv - opcode, status and state encodings shared by the CAM entry manager
package cam_entry_mgr_pkg;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;

    localparam logic [1:0] ST_OK        = 2'b00;
    localparam logic [1:0] ST_NOT_FOUND = 2'b01;
    localparam logic [1:0] ST_FULL      = 2'b10;
    localparam logic [1:0] ST_BAD_OP    = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CMP    = 3'd1,
        DECIDE = 3'd2,
        WRITE  = 3'd3,
        RESP   = 3'd4,
        FLUSH  = 3'd5
    } state_t;

endpackage

// File: rtl/cam_simple.sv
// rtl/cam_simple.sv - small register CAM: registered compare key, single-cycle writes, lowest index wins
module cam_simple #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_delete,
    input  logic                  write_enable,
    output logic                  write_busy,
    input  logic [DATA_WIDTH-1:0] compare_data,
    output logic                  match,
    output logic [ADDR_WIDTH-1:0] match_addr
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_keys [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [DATA_WIDTH-1:0] r_cmp;

    assign write_busy = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_cmp   <= '0;
        end else begin
            r_cmp <= compare_data;
            if (write_enable) r_valid[write_addr] <= !write_delete;
        end
    end

    always_ff @(posedge clk) begin
        if (write_enable) r_keys[write_addr] <= write_data;
    end

    always_comb begin
        match      = 1'b0;
        match_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_valid[i] && r_keys[i] == r_cmp) begin
                match      = 1'b1;
                match_addr = ADDR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/priority_encoder.sv
// rtl/priority_encoder.sv - one-hot-agnostic priority encoder; LSB_PRIORITY "HIGH" selects the lowest set bit
module priority_encoder #(
    parameter int WIDTH        = 4,
    parameter     LSB_PRIORITY = "LOW",
    parameter int ENC_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] input_unencoded,
    output logic             output_valid,
    output logic [ENC_W-1:0] output_encoded
);

    always_comb begin
        output_valid   = |input_unencoded;
        output_encoded = '0;
        if (LSB_PRIORITY == "HIGH") begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (input_unencoded[i]) output_encoded = ENC_W'(i);
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (input_unencoded[i]) output_encoded = ENC_W'(i);
            end
        end
    end

endmodule

// File: rtl/cam_entry_mgr.sv
// rtl/cam_entry_mgr.sv - LOOKUP/INSERT/DELETE front end for cam_simple with free-slot tracking
// Optional bulk delete of every slot is built when CAM_ENTRY_MGR_FLUSH_EN is defined.
module cam_entry_mgr
    import cam_entry_mgr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [DATA_WIDTH-1:0] req_key,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  rsp_existed,
    output logic [ADDR_WIDTH:0]   entry_count,
`ifdef CAM_ENTRY_MGR_FLUSH_EN
    input  logic                  flush_req,
    output logic                  flush_busy,
`endif
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_write_data,
    output logic                  cam_write_delete,
    output logic                  cam_write_enable,
    input  logic                  cam_write_busy,
    output logic [DATA_WIDTH-1:0] cam_compare_data,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] CNT_MAX = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_run;
    logic [1:0]            r_op;
    logic [DATA_WIDTH-1:0] r_key;
    logic [DEPTH-1:0]      r_free;
    logic [ADDR_WIDTH:0]   r_count;
    logic [1:0]            r_rsp_status;
    logic [ADDR_WIDTH-1:0] r_rsp_addr;
    logic                  r_rsp_existed;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;
    logic                  r_wr_del;

    logic                  w_free_valid;
    logic [ADDR_WIDTH-1:0] w_free_idx;
    logic                  w_accept;
    logic                  w_flush_start;
    logic                  w_issue;
    logic                  w_dec_write;
    logic [1:0]            w_dec_status;
    logic [ADDR_WIDTH-1:0] w_dec_addr;
    logic                  w_dec_existed;

`ifdef CAM_ENTRY_MGR_FLUSH_EN
    logic [ADDR_WIDTH-1:0] r_flush_addr;
    logic                  w_flush_last;

    assign w_flush_start = (r_state == IDLE) && r_run && flush_req;
    assign w_flush_last  = (r_flush_addr == ADDR_WIDTH'(DEPTH - 1));
`else
    assign w_flush_start = 1'b0;
`endif

    assign w_accept = req_valid && req_ready && !w_flush_start;
    assign w_issue  = (r_state == WRITE) && !cam_write_busy;

    priority_encoder #(
        .WIDTH        (DEPTH),
        .LSB_PRIORITY ("HIGH"),
        .ENC_W        (ADDR_WIDTH)
    ) u_free_enc (
        .input_unencoded (r_free),
        .output_valid    (w_free_valid),
        .output_encoded  (w_free_idx)
    );

    // r_run keeps req_ready low while reset is asserted even though the state reads IDLE.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= IDLE;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_flush_start)  w_state_next = FLUSH;
                else if (w_accept)  w_state_next = CMP;
            end
            CMP:    w_state_next = DECIDE;
            DECIDE: w_state_next = w_dec_write ? WRITE : RESP;
            WRITE:  if (!cam_write_busy) w_state_next = RESP;
            RESP:   if (rsp_ready) w_state_next = IDLE;
`ifdef CAM_ENTRY_MGR_FLUSH_EN
            FLUSH:  if (!cam_write_busy && w_flush_last) w_state_next = IDLE;
`endif
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready        = r_run && (r_state == IDLE);
        rsp_valid        = (r_state == RESP);
        rsp_status       = r_rsp_status;
        rsp_addr         = r_rsp_addr;
        rsp_existed      = r_rsp_existed;
        entry_count      = r_count;
        cam_write_addr   = r_wr_addr;
        cam_write_data   = r_wr_data;
        cam_write_delete = r_wr_del;
        cam_write_enable = r_wr_en;
        cam_compare_data = r_key;
`ifdef CAM_ENTRY_MGR_FLUSH_EN
        flush_busy       = (r_state == FLUSH);
`endif
    end

    always_comb begin
        w_dec_write   = 1'b0;
        w_dec_status  = ST_OK;
        w_dec_addr    = '0;
        w_dec_existed = 1'b0;
        case (r_op)
            OP_LOOKUP: begin
                if (cam_match) w_dec_addr   = cam_match_addr;
                else           w_dec_status = ST_NOT_FOUND;
            end
            OP_INSERT: begin
                if (cam_match) begin
                    w_dec_write   = 1'b1;
                    w_dec_addr    = cam_match_addr;
                    w_dec_existed = 1'b1;
                end else if (w_free_valid) begin
                    w_dec_write = 1'b1;
                    w_dec_addr  = w_free_idx;
                end else begin
                    w_dec_status = ST_FULL;
                end
            end
            OP_DELETE: begin
                if (cam_match) begin
                    w_dec_write = 1'b1;
                    w_dec_addr  = cam_match_addr;
                end else begin
                    w_dec_status = ST_NOT_FOUND;
                end
            end
            default: w_dec_status = ST_BAD_OP;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_op          <= OP_LOOKUP;
            r_key         <= '0;
            r_free        <= '1;
            r_count       <= '0;
            r_rsp_status  <= ST_OK;
            r_rsp_addr    <= '0;
            r_rsp_existed <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_wr_del      <= 1'b0;
`ifdef CAM_ENTRY_MGR_FLUSH_EN
            r_flush_addr  <= '0;
`endif
        end else begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_wr_del  <= 1'b0;
            if (w_accept) begin
                r_op  <= req_op;
                r_key <= req_key;
            end
            if (r_state == DECIDE) begin
                r_rsp_status  <= w_dec_status;
                r_rsp_addr    <= w_dec_addr;
                r_rsp_existed <= w_dec_existed;
            end
            // Count moves only when a bitmap bit actually flips, so in-place updates leave it alone.
            if (w_issue) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_rsp_addr;
                r_wr_data <= r_key;
                r_wr_del  <= (r_op == OP_DELETE);
                if (r_op == OP_DELETE) begin
                    if (!r_free[r_rsp_addr]) begin
                        r_free[r_rsp_addr] <= 1'b1;
                        if (r_count != '0) r_count <= r_count - CNT_ONE;
                    end
                end else if (r_free[r_rsp_addr]) begin
                    r_free[r_rsp_addr] <= 1'b0;
                    if (r_count != CNT_MAX) r_count <= r_count + CNT_ONE;
                end
            end
`ifdef CAM_ENTRY_MGR_FLUSH_EN
            if (r_state == FLUSH && !cam_write_busy) begin
                r_wr_en      <= 1'b1;
                r_wr_addr    <= r_flush_addr;
                r_wr_del     <= 1'b1;
                r_flush_addr <= r_flush_addr + ADDR_WIDTH'(1);
                if (w_flush_last) begin
                    r_free       <= '1;
                    r_count      <= '0;
                    r_flush_addr <= '0;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cam_entry_mgr.sv
// tb/tb_cam_entry_mgr.sv - directed bench for cam_entry_mgr paired with cam_simple
module tb_cam_entry_mgr;

    localparam int DW = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_key;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic          rsp_existed;
    logic [AW:0]   entry_count;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_write_data;
    logic          cam_write_delete;
    logic          cam_write_enable;
    logic          cam_write_busy;
    logic          w_cam_busy;
    logic          tb_busy;
    logic [DW-1:0] cam_compare_data;
    logic          cam_match;
    logic [AW-1:0] cam_match_addr;
`ifdef CAM_ENTRY_MGR_FLUSH_EN
    logic          flush_req;
    logic          flush_busy;
`endif

    int total = 0;
    int bad   = 0;
    int wr_cnt = 0;
    logic [AW-1:0] last_wa;
    logic          last_wd;
    logic [DW-1:0] last_wdata;
    bit  fl_on = 0;
    int  fl_n = 0;
    int  fl_err = 0;

    always #5 clk = ~clk;

    assign cam_write_busy = w_cam_busy | tb_busy;

    cam_entry_mgr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .aresetn          (aresetn),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_key          (req_key),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_status       (rsp_status),
        .rsp_addr         (rsp_addr),
        .rsp_existed      (rsp_existed),
        .entry_count      (entry_count),
`ifdef CAM_ENTRY_MGR_FLUSH_EN
        .flush_req        (flush_req),
        .flush_busy       (flush_busy),
`endif
        .cam_write_addr   (cam_write_addr),
        .cam_write_data   (cam_write_data),
        .cam_write_delete (cam_write_delete),
        .cam_write_enable (cam_write_enable),
        .cam_write_busy   (cam_write_busy),
        .cam_compare_data (cam_compare_data),
        .cam_match        (cam_match),
        .cam_match_addr   (cam_match_addr)
    );

    cam_simple #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_cam (
        .clk          (clk),
        .rst          (!aresetn),
        .write_addr   (cam_write_addr),
        .write_data   (cam_write_data),
        .write_delete (cam_write_delete),
        .write_enable (cam_write_enable),
        .write_busy   (w_cam_busy),
        .compare_data (cam_compare_data),
        .match        (cam_match),
        .match_addr   (cam_match_addr)
    );

    always @(posedge clk) begin
        if (cam_write_enable) begin
            wr_cnt++;
            last_wa    = cam_write_addr;
            last_wd    = cam_write_delete;
            last_wdata = cam_write_data;
            if (fl_on) begin
                if (!cam_write_delete || cam_write_addr != AW'(fl_n)) fl_err++;
                fl_n++;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [1:0] op, input logic [DW-1:0] key,
                          input int busy_n, input int hold_n,
                          output int lat, output logic [1:0] st, output logic [AW-1:0] ad,
                          output logic ex, output int nwr);
        int  wait_c;
        int  w0;
        bit  got;
        bit  stable;
        @(negedge clk);
        wait_c = 0;
        while (!req_ready && wait_c < 50) begin
            @(negedge clk);
            wait_c++;
        end
        if (!req_ready) chk("ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_key   = key;
        rsp_ready = (hold_n == 0);
        w0        = wr_cnt;
        @(posedge clk);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            req_valid = 1'b0;
            if (busy_n > 0 && lat == 3) tb_busy = 1'b1;
            if (busy_n > 0 && lat == 3 + busy_n) tb_busy = 1'b0;
            if (rsp_valid) got = 1;
            else @(posedge clk);
        end
        tb_busy = 1'b0;
        st = rsp_status;
        ad = rsp_addr;
        ex = rsp_existed;
        if (!got) begin
            chk("rsp_timeout", 0, 1);
            rsp_ready = 1'b1;
            nwr = wr_cnt - w0;
            return;
        end
        if (hold_n > 0) begin
            stable = 1;
            repeat (hold_n) begin
                @(posedge clk);
                @(negedge clk);
                if (!rsp_valid || rsp_status != st || rsp_addr != ad ||
                    rsp_existed != ex || req_ready) stable = 0;
            end
            chk("hold_stable", stable, 1);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        nwr = wr_cnt - w0;
    endtask

    initial begin
        int            lat;
        logic [1:0]    st;
        logic [AW-1:0] ad;
        logic          ex;
        int            nwr;
        int            errs;

        aresetn   = 1'b0;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_key   = '0;
        rsp_ready = 1'b1;
        tb_busy   = 1'b0;
`ifdef CAM_ENTRY_MGR_FLUSH_EN
        flush_req = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_count", entry_count, 0);
        chk("rst_wr_en", cam_write_enable, 0);
        chk("rst_cmp_data", cam_compare_data, 0);
        aresetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("idle_req_ready", req_ready, 1);

        do_req(2'b01, 64'hA5, 0, 0, lat, st, ad, ex, nwr);
        chk("ins1_lat", lat, 4);
        chk("ins1_status", st, 0);
        chk("ins1_addr", ad, 0);
        chk("ins1_existed", ex, 0);
        chk("ins1_nwr", nwr, 1);
        chk("ins1_wa", last_wa, 0);
        chk("ins1_wd", last_wd, 0);
        chk("ins1_wdata", last_wdata, 64'hA5);
        chk("ins1_count", entry_count, 1);
        chk("ins1_rsp_drop", rsp_valid, 0);

        do_req(2'b01, 64'hA5, 0, 0, lat, st, ad, ex, nwr);
        chk("ins2_status", st, 0);
        chk("ins2_addr", ad, 0);
        chk("ins2_existed", ex, 1);
        chk("ins2_count", entry_count, 1);

        do_req(2'b00, 64'hA5, 0, 0, lat, st, ad, ex, nwr);
        chk("lk1_lat", lat, 3);
        chk("lk1_status", st, 0);
        chk("lk1_addr", ad, 0);
        chk("lk1_nwr", nwr, 0);

        do_req(2'b00, 64'h77, 0, 0, lat, st, ad, ex, nwr);
        chk("lk2_status", st, 1);
        chk("lk2_addr", ad, 0);

        do_req(2'b11, 64'hA5, 0, 0, lat, st, ad, ex, nwr);
        chk("bad_status", st, 3);
        chk("bad_lat", lat, 3);
        chk("bad_nwr", nwr, 0);

        do_req(2'b10, 64'hA5, 0, 0, lat, st, ad, ex, nwr);
        chk("del1_status", st, 0);
        chk("del1_wd", last_wd, 1);
        chk("del1_count", entry_count, 0);

        errs = 0;
        for (int k = 1; k <= 32; k++) begin
            do_req(2'b01, 64'(k), 0, 0, lat, st, ad, ex, nwr);
            if (st != 2'b00 || ad != AW'(k - 1)) errs++;
        end
        chk("fill_addrs", errs, 0);
        chk("fill_count", entry_count, 32);

        do_req(2'b01, 64'd33, 0, 0, lat, st, ad, ex, nwr);
        chk("full_status", st, 2);
        chk("full_addr", ad, 0);
        chk("full_nwr", nwr, 0);
        chk("full_count", entry_count, 32);

        do_req(2'b10, 64'd5, 0, 0, lat, st, ad, ex, nwr);
        chk("del5_status", st, 0);
        chk("del5_addr", ad, 4);
        chk("del5_wa", last_wa, 4);
        chk("del5_count", entry_count, 31);

        do_req(2'b01, 64'd33, 0, 0, lat, st, ad, ex, nwr);
        chk("ins33_status", st, 0);
        chk("ins33_addr", ad, 4);
        chk("ins33_count", entry_count, 32);

        do_req(2'b10, 64'd99, 0, 0, lat, st, ad, ex, nwr);
        chk("del99_status", st, 1);

        do_req(2'b10, 64'd10, 0, 0, lat, st, ad, ex, nwr);
        chk("del10_addr", ad, 9);

        do_req(2'b01, 64'h100, 3, 0, lat, st, ad, ex, nwr);
        chk("busy_lat", lat, 7);
        chk("busy_nwr", nwr, 1);
        chk("busy_addr", ad, 9);
        chk("busy_count", entry_count, 32);

        do_req(2'b00, 64'h100, 0, 5, lat, st, ad, ex, nwr);
        chk("hold_status", st, 0);
        chk("hold_addr", ad, 9);

        do_req(2'b10, 64'd20, 0, 0, lat, st, ad, ex, nwr);
        chk("del20_addr", ad, 19);

        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_key   = 64'h200;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        tb_busy   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        aresetn = 1'b0;
        #1;
        chk("mid_req_ready", req_ready, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_addr", rsp_addr, 0);
        chk("mid_count", entry_count, 0);
        chk("mid_wr_en", cam_write_enable, 0);
        chk("mid_cmp_data", cam_compare_data, 0);
        tb_busy = 1'b0;
        repeat (2) @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);

        do_req(2'b00, 64'h200, 0, 0, lat, st, ad, ex, nwr);
        chk("post_lk200", st, 1);
        chk("post_count", entry_count, 0);
        do_req(2'b00, 64'd1, 0, 0, lat, st, ad, ex, nwr);
        chk("post_lk1", st, 1);

`ifdef CAM_ENTRY_MGR_FLUSH_EN
        begin
            int busy_c;
            bit rdy_seen;
            for (int k = 7; k <= 9; k++) do_req(2'b01, 64'(k), 0, 0, lat, st, ad, ex, nwr);
            chk("fl_pre_count", entry_count, 3);
            fl_on  = 1;
            fl_n   = 0;
            fl_err = 0;
            @(negedge clk);
            flush_req = 1'b1;
            @(posedge clk);
            @(negedge clk);
            flush_req = 1'b0;
            busy_c   = 0;
            rdy_seen = 0;
            while (flush_busy && busy_c < 100) begin
                busy_c++;
                if (req_ready) rdy_seen = 1;
                @(posedge clk);
                @(negedge clk);
            end
            @(posedge clk);
            @(negedge clk);
            fl_on = 0;
            chk("fl_busy_cycles", busy_c, 32);
            chk("fl_nwr", fl_n, 32);
            chk("fl_addr_seq", fl_err, 0);
            chk("fl_ready_low", rdy_seen, 0);
            chk("fl_count", entry_count, 0);
            chk("fl_no_rsp", rsp_valid, 0);
            do_req(2'b00, 64'd8, 0, 0, lat, st, ad, ex, nwr);
            chk("fl_lookup", st, 1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cam_entry_mgr.md
Name: cam_entry_mgr

Overview:
- Control stage directly upstream of the CAM (cam_simple).
- Owns the CAM's write port and compare_data.
- Serves LOOKUP / INSERT / DELETE requests by key from the table-config path; tracks free slots; returns a status and address.
- Hides CAM slot allocation from the control plane.

Parameters:
- DATA_WIDTH, 64, key width; must equal the CAM's DATA_WIDTH.
- ADDR_WIDTH, 5, CAM address width; depth D = 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request ready
- req_op  in  2  00 LOOKUP, 01 INSERT, 10 DELETE, 11 reserved
- req_key  in  DATA_WIDTH  key
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_status  out  2  00 OK, 01 NOT_FOUND, 10 FULL, 11 BAD_OP
- rsp_addr  out  ADDR_WIDTH  matched or allocated slot (0 when status is not OK)
- rsp_existed  out  1  INSERT hit an existing key (in-place update)
- entry_count  out  ADDR_WIDTH+1  occupied entries
- cam_write_addr  out  ADDR_WIDTH  to CAM
- cam_write_data  out  DATA_WIDTH  to CAM
- cam_write_delete  out  1  to CAM
- cam_write_enable  out  1  to CAM
- cam_write_busy  in  1  from CAM
- cam_compare_data  out  DATA_WIDTH  to CAM
- cam_match  in  1  from CAM
- cam_match_addr  in  ADDR_WIDTH  from CAM (lowest matching index)

Behaviour:
- Reset (async, aresetn=0):
  - state IDLE; free bitmap all ones; entry_count 0.
  - All outputs 0 except req_ready, which is 0 during reset and 1 in IDLE after release.
  - The integrator drives the CAM rst from !aresetn so CAM valids clear in the same reset.
- Handshake:
  - req_ready = (state==IDLE). Request accepted on an edge where req_valid && req_ready; op and key captured into key_q/op_q.
  - rsp_* are held stable while rsp_valid && !rsp_ready. Response is consumed on rsp_valid && rsp_ready, then state returns to IDLE.
- cam_compare_data = key_q (registered), held constant from accept to response.
- States, with the accept edge as cycle 0:
  - CMP (cycle 1): the CAM registers the compare.
  - DECIDE (cycle 2): sample cam_match / cam_match_addr and decide:
    - LOOKUP: hit gives OK with match_addr; miss gives NOT_FOUND. Go to RESP.
    - INSERT, hit: WRITE at match_addr, rsp_existed=1, count unchanged.
    - INSERT, miss with a free slot: WRITE at the lowest free index, count+1, clear the free bit.
    - INSERT, miss with no free slot: FULL, go to RESP.
    - DELETE, hit: WRITE with delete=1 at match_addr, count-1, set the free bit.
    - DELETE, miss: NOT_FOUND.
    - Reserved op: BAD_OP, no CAM access.
  - WRITE: cam_write_enable (registered) is high for exactly one cycle, issued on the first cycle with cam_write_busy=0; held in WRITE while busy. Bitmap and count update on the same edge the write is issued. Then go to RESP.
  - RESP: rsp_valid=1. First high in cycle 3 (no write) or cycle 4 (write, not busy).
- Write outputs are 0 outside the write cycle. A later request's compare starts at least 2 edges after a CAM write, so it always sees the updated CAM.
- entry_count never wraps: saturates at D, never drops below 0. The bitmap is the source of truth.
- Reset mid-operation: any state returns to IDLE. An in-flight response is dropped; a partially issued write is discarded with the CAM reset.

Optional Feature:
- Macro: CAM_ENTRY_MGR_FLUSH_EN
- With the macro defined:
  - Adds input flush_req (1) and output flush_busy (1).
  - flush_req is sampled in IDLE with priority over req_valid; enters FLUSH.
  - FLUSH issues delete writes to addresses 0..D-1, one per non-busy cycle. req_ready=0 and flush_busy=1 throughout.
  - On completion: bitmap all ones, entry_count 0, return to IDLE. No response is generated.
- Without the macro: ports, state and logic are absent.

Decomposition:
- Package cam_entry_mgr_pkg holds:
  - op encodings (OP_LOOKUP, OP_INSERT, OP_DELETE);
  - status encodings (ST_OK, ST_NOT_FOUND, ST_FULL, ST_BAD_OP);
  - state enum (IDLE, CMP, DECIDE, WRITE, RESP, FLUSH).
- Free-slot selection instantiates the existing priority_encoder on the free bitmap (LSB_PRIORITY "HIGH"). No new sub-module.
- Bench pairs the block with cam_simple.

Test Plan:
- Reset, INSERT key 0xA5 -> rsp_valid at cycle 4, OK, addr 0, existed 0, entry_count 1; CAM sees one write to addr 0, delete 0.
- INSERT 0xA5 again -> OK, addr 0, existed 1, count stays 1. LOOKUP 0xA5 -> OK, addr 0 at cycle 3. LOOKUP 0x77 -> NOT_FOUND, addr 0.
- Fill all 32 slots with keys 1..32, INSERT 33 -> FULL, no cam_write_enable pulse, count 32. DELETE key 5 -> OK addr 4; INSERT 33 -> OK addr 4.
- Hold cam_write_busy=1 for 3 cycles during an INSERT -> single write pulse after busy drops; rsp_valid at cycle 7. Hold rsp_ready=0 for 5 cycles -> rsp fields stable, req_ready=0.
- Deassert aresetn while in WRITE with busy high -> all outputs 0 immediately; after release, LOOKUP of the prior key -> NOT_FOUND, count 0.
- With CAM_ENTRY_MGR_FLUSH_EN: 3 entries present, pulse flush_req -> 32 delete writes to addrs 0..31, flush_busy high 32 cycles, count 0; a following LOOKUP -> NOT_FOUND.
